// File: rtl/wallace_mul_sched.sv
// rtl/wallace_mul_sched.sv - round-robin scheduler sharing one 32x32 multiplier between two requesters
// Optional feature macro: WALLACE_MUL_SIGNED_EN (two's complement operands via sign-magnitude).

// Combinational 32x32 -> 64 unsigned multiplier; carry-save reduction is left to synthesis.
module create (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] s
);
  assign s = {32'd0, a} * {32'd0, b};
endmodule

module wallace_mul_sched #(
  parameter int WIDTH       = 32,
  parameter int CALC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res_p,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               id_q, id_d;
  logic               last_grant_q, last_grant_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;
  logic               res_id_q, res_id_d;
  logic [2*WIDTH-1:0] res_p_q, res_p_d;

  logic               grant;
  logic [WIDTH-1:0]   sel_a, sel_b, op_a, op_b;
  logic [2*WIDTH-1:0] prod, prod_res;

`ifdef WALLACE_MUL_SIGNED_EN
  logic sign_q, sign_d;
`endif

  // Round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
  always_comb begin
    grant = req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    sel_a = grant ? req1_a : req0_a;
    sel_b = grant ? req1_b : req0_b;
  end

  assign req0_ready = (state_q == IDLE) & ~grant & req0_valid;
  assign req1_ready = (state_q == IDLE) &  grant & req1_valid;

  // Operand conditioning: magnitudes in signed mode so the shared core stays unsigned.
  always_comb begin
    op_a = sel_a;
    op_b = sel_b;
`ifdef WALLACE_MUL_SIGNED_EN
    if (sel_a[WIDTH-1]) op_a = ~sel_a + 1'b1;
    if (sel_b[WIDTH-1]) op_b = ~sel_b + 1'b1;
`endif
  end

  create u_create (
    .a (a_q),
    .b (b_q),
    .s (prod)
  );

  // Restore the sign of the product before it is captured.
  always_comb begin
    prod_res = prod;
`ifdef WALLACE_MUL_SIGNED_EN
    if (sign_q) prod_res = ~prod + 1'b1;
`endif
  end

  // Job sequencing: accept one job, count out the settle time, hold the result until taken.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_p_d      = res_p_q;
`ifdef WALLACE_MUL_SIGNED_EN
    sign_d       = sign_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          a_d          = op_a;
          b_d          = op_b;
          id_d         = grant;
          last_grant_d = grant;
          cnt_d        = CNT_INIT;
          state_d      = CALC;
`ifdef WALLACE_MUL_SIGNED_EN
          sign_d       = sel_a[WIDTH-1] ^ sel_b[WIDTH-1];
`endif
        end
      end
      CALC: begin
        if (cnt_q == 4'd0) begin
          res_p_d     = prod_res;
          res_id_d    = id_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any job in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= 4'd0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_p_q      <= '0;
`ifdef WALLACE_MUL_SIGNED_EN
      sign_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_p_q      <= res_p_d;
`ifdef WALLACE_MUL_SIGNED_EN
      sign_q       <= sign_d;
`endif
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_p     = res_p_q;
  assign busy      = (state_q != IDLE);

endmodule
